// File: rtl/apb_m_pkg.sv
// apb_m_pkg: shared state encoding and default widths for the APB requester
// bridge. Optional feature macro used by this slice: APB_M_TIMEOUT_EN.
package apb_m_pkg;

   localparam int unsigned ADDR_W_C      = 32;
   localparam int unsigned DATA_W_C      = 32;
   localparam int unsigned TIMEOUT_CYC_C = 16;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      SETUP  = 2'b01,
      ACCESS = 2'b10
   } apb_state_e;

endpackage : apb_m_pkg

// File: rtl/apb_m_if.sv
// apb_m_if: command/response handshake plus APB requester bus, bundled so the
// bridge sees one port. The master modport is the bridge's view; the slave
// modport is the view of whoever issues commands and models the completer.
interface apb_m_if import apb_m_pkg::*; #(
   parameter int unsigned ADDR_W = ADDR_W_C,
   parameter int unsigned DATA_W = DATA_W_C
);

   // command side
   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_write;
   logic [ADDR_W-1:0] cmd_addr;
   logic [DATA_W-1:0] cmd_wdata;

   // response side
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;

   // APB requester outputs
   logic [ADDR_W-1:0] paddr;
   logic [DATA_W-1:0] pwdata;
   logic              pwrite;
   logic              psel;
   logic              penable;

   // APB completer inputs
   logic [DATA_W-1:0] prdata;
   logic              pready;
   logic              pslverr;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
      input  prdata, pready, pslverr,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
      output paddr, pwdata, pwrite, psel, penable
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
      output prdata, pready, pslverr,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
      input  paddr, pwdata, pwrite, psel, penable
   );

endinterface : apb_m_if

// File: rtl/apb_m_wdog.sv
// apb_m_wdog: counts consecutive ACCESS cycles and flags the cycle in which
// the TIMEOUT_CYC-th one is being completed. Only built with APB_M_TIMEOUT_EN.
module apb_m_wdog import apb_m_pkg::*; #(
   parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_C
) (
   input  logic clk,
   input  logic rst_n,
   input  logic active,
   output logic expire
);

   localparam int unsigned       CNT_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CNT_W-1:0] LAST_C = CNT_W'(TIMEOUT_CYC - 1);

   logic [CNT_W-1:0] cnt_r;

   // Count ACCESS cycles already elapsed; cleared whenever not in ACCESS.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r <= {CNT_W{1'b0}};
      end else if (!active) begin
         cnt_r <= {CNT_W{1'b0}};
      end else if (cnt_r != LAST_C) begin
         cnt_r <= cnt_r + CNT_W'(1'b1);
      end else begin
         cnt_r <= cnt_r;
      end
   end

   // The current ACCESS cycle is the last one allowed.
   assign expire = active && (cnt_r == LAST_C);

endmodule : apb_m_wdog

// File: rtl/apb_m_bridge.sv
// apb_m_bridge: turns a valid/ready command into a single APB transfer
// (IDLE -> SETUP -> ACCESS) and returns a one-cycle response pulse.
// Optional macro APB_M_TIMEOUT_EN adds an ACCESS watchdog that aborts a
// transfer with an error after TIMEOUT_CYC cycles without pready.
module apb_m_bridge import apb_m_pkg::*; #(
   parameter int unsigned ADDR_W      = ADDR_W_C,
   parameter int unsigned DATA_W      = DATA_W_C,
   parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_C
) (
   input  logic    clk,
   input  logic    rst_n,
   apb_m_if.master bus
);

   apb_state_e state_r, state_s;

   logic              accept_s, done_s, abort_s, expire_s;

   logic              cmd_ready_r, cmd_ready_s;
   logic [ADDR_W-1:0] paddr_r,     paddr_s;
   logic [DATA_W-1:0] pwdata_r,    pwdata_s;
   logic              pwrite_r,    pwrite_s;
   logic              psel_r,      psel_s;
   logic              penable_r,   penable_s;
   logic              rsp_valid_r, rsp_valid_s;
   logic [DATA_W-1:0] rsp_rdata_r, rsp_rdata_s;
   logic              rsp_err_r,   rsp_err_s;

`ifdef APB_M_TIMEOUT_EN
   apb_m_wdog #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_wdog (
      .clk    (clk),
      .rst_n  (rst_n),
      .active (state_r == ACCESS),
      .expire (expire_s)
   );
`else
   // No watchdog: ACCESS never expires and the limit has no meaning.
   assign expire_s = 1'b0 & (TIMEOUT_CYC != 32'd0);
`endif

   // cmd_ready is registered, so also gate on the state to stay safe.
   assign accept_s = (state_r == IDLE) && cmd_ready_r && bus.cmd_valid;
   // pready takes priority over an expiring watchdog in the same cycle.
   assign done_s   = (state_r == ACCESS) && bus.pready;
   assign abort_s  = (state_r == ACCESS) && !bus.pready && expire_s;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state decode.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               state_s = SETUP;
            end else begin
               state_s = IDLE;
            end
         end
         SETUP: begin
            state_s = ACCESS;
         end
         ACCESS: begin
            if (done_s || abort_s) begin
               state_s = IDLE;
            end else begin
               state_s = ACCESS;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // Next values of every registered output, derived from the next state.
   always_comb begin
      cmd_ready_s = (state_s == IDLE);
      psel_s      = (state_s != IDLE);
      penable_s   = (state_s == ACCESS);

      paddr_s     = paddr_r;
      pwdata_s    = pwdata_r;
      pwrite_s    = pwrite_r;
      if (accept_s) begin
         paddr_s  = bus.cmd_addr;
         pwdata_s = bus.cmd_wdata;
         pwrite_s = bus.cmd_write;
      end else begin
         paddr_s  = paddr_r;
         pwdata_s = pwdata_r;
         pwrite_s = pwrite_r;
      end

      rsp_valid_s = 1'b0;
      rsp_rdata_s = rsp_rdata_r;
      rsp_err_s   = rsp_err_r;
      if (done_s) begin
         rsp_valid_s = 1'b1;
         rsp_err_s   = bus.pslverr;
         if (pwrite_r) begin
            rsp_rdata_s = {DATA_W{1'b0}};
         end else begin
            rsp_rdata_s = bus.prdata;
         end
      end else if (abort_s) begin
         rsp_valid_s = 1'b1;
         rsp_err_s   = 1'b1;
         rsp_rdata_s = {DATA_W{1'b0}};
      end else begin
         rsp_valid_s = 1'b0;
         rsp_rdata_s = rsp_rdata_r;
         rsp_err_s   = rsp_err_r;
      end
   end

   // Output registers; reset abandons any transfer in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmd_ready_r <= 1'b0;
         paddr_r     <= {ADDR_W{1'b0}};
         pwdata_r    <= {DATA_W{1'b0}};
         pwrite_r    <= 1'b0;
         psel_r      <= 1'b0;
         penable_r   <= 1'b0;
         rsp_valid_r <= 1'b0;
         rsp_rdata_r <= {DATA_W{1'b0}};
         rsp_err_r   <= 1'b0;
      end else begin
         cmd_ready_r <= cmd_ready_s;
         paddr_r     <= paddr_s;
         pwdata_r    <= pwdata_s;
         pwrite_r    <= pwrite_s;
         psel_r      <= psel_s;
         penable_r   <= penable_s;
         rsp_valid_r <= rsp_valid_s;
         rsp_rdata_r <= rsp_rdata_s;
         rsp_err_r   <= rsp_err_s;
      end
   end

   assign bus.cmd_ready = cmd_ready_r;
   assign bus.paddr     = paddr_r;
   assign bus.pwdata    = pwdata_r;
   assign bus.pwrite    = pwrite_r;
   assign bus.psel      = psel_r;
   assign bus.penable   = penable_r;
   assign bus.rsp_valid = rsp_valid_r;
   assign bus.rsp_rdata = rsp_rdata_r;
   assign bus.rsp_err   = rsp_err_r;

endmodule : apb_m_bridge

// File: tb/tb_apb_m_bridge.sv
// tb_apb_m_bridge: directed self-checking bench for apb_m_bridge. Outputs are
// sampled 1 ns after each rising edge; inputs change at the same point.
// Honours APB_M_TIMEOUT_EN when the design is built with it.
module tb_apb_m_bridge;

   localparam int unsigned TO_CYC = 16;

   logic clk;
   logic rst_n;
   int   n_assert;
   int   n_fail;
   int   seen;

   apb_m_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   apb_m_bridge #(
      .ADDR_W      (32),
      .DATA_W      (32),
      .TIMEOUT_CYC (TO_CYC)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_assert = 0;
      n_fail   = 0;
      seen     = 0;
      rst_n         = 1'b0;
      bus.cmd_valid = 1'b0;
      bus.cmd_write = 1'b0;
      bus.cmd_addr  = 32'h0;
      bus.cmd_wdata = 32'h0;
      bus.prdata    = 32'h0;
      bus.pready    = 1'b0;
      bus.pslverr   = 1'b0;

      // ---- reset values
      step(); step();
      chk("rst_psel",      bus.psel,      64'h0);
      chk("rst_penable",   bus.penable,   64'h0);
      chk("rst_pwrite",    bus.pwrite,    64'h0);
      chk("rst_paddr",     bus.paddr,     64'h0);
      chk("rst_pwdata",    bus.pwdata,    64'h0);
      chk("rst_rsp_valid", bus.rsp_valid, 64'h0);
      chk("rst_rsp_rdata", bus.rsp_rdata, 64'h0);
      chk("rst_rsp_err",   bus.rsp_err,   64'h0);
      chk("rst_cmd_ready", bus.cmd_ready, 64'h0);
      rst_n = 1'b1;
      chk("rel_ready_low", bus.cmd_ready, 64'h0);
      step();
      chk("rel_ready_high", bus.cmd_ready, 64'h1);

      // ---- write, pready tied high
      bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1;
      bus.cmd_addr  = 32'h10; bus.cmd_wdata = 32'hDEADBEEF; bus.pready = 1'b1;
      step();                                   // acceptance edge N
      chk("wr_setup_psel",    bus.psel,      64'h1);
      chk("wr_setup_penable", bus.penable,   64'h0);
      chk("wr_paddr",         bus.paddr,     64'h10);
      chk("wr_pwdata",        bus.pwdata,    64'hDEADBEEF);
      chk("wr_pwrite",        bus.pwrite,    64'h1);
      chk("wr_ready_low",     bus.cmd_ready, 64'h0);
      bus.cmd_valid = 1'b0; bus.cmd_addr = 32'hFFFFFFFF; bus.cmd_wdata = 32'h0;
      step();
      chk("wr_access_penable", bus.penable,   64'h1);
      chk("wr_access_psel",    bus.psel,      64'h1);
      chk("wr_access_rsp",     bus.rsp_valid, 64'h0);
      chk("wr_access_pwdata",  bus.pwdata,    64'hDEADBEEF);
      step();
      chk("wr_rsp_valid", bus.rsp_valid, 64'h1);
      chk("wr_rsp_err",   bus.rsp_err,   64'h0);
      chk("wr_rsp_rdata", bus.rsp_rdata, 64'h0);
      chk("wr_end_psel",  bus.psel,      64'h0);
      chk("wr_end_pen",   bus.penable,   64'h0);
      chk("wr_end_ready", bus.cmd_ready, 64'h1);
      chk("wr_end_paddr", bus.paddr,     64'h10);
      step();
      chk("wr_rsp_pulse", bus.rsp_valid, 64'h0);

      // ---- read with three wait states
      bus.pready = 1'b0; bus.prdata = 32'hCAFE0000;
      bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0;
      bus.cmd_addr = 32'h20; bus.cmd_wdata = 32'h55555555;
      step();
      chk("rd_setup_psel",   bus.psel,    64'h1);
      chk("rd_setup_pen",    bus.penable, 64'h0);
      chk("rd_setup_pwrite", bus.pwrite,  64'h0);
      chk("rd_setup_paddr",  bus.paddr,   64'h20);
      bus.cmd_valid = 1'b0; bus.cmd_addr = 32'h0; bus.cmd_write = 1'b1;
      step();
      chk("rd_access_pen", bus.penable, 64'h1);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("rd_wait_psel",   bus.psel,      64'h1);
         chk("rd_wait_pen",    bus.penable,   64'h1);
         chk("rd_wait_paddr",  bus.paddr,     64'h20);
         chk("rd_wait_pwrite", bus.pwrite,    64'h0);
         chk("rd_wait_rsp",    bus.rsp_valid, 64'h0);
      end
      bus.pready = 1'b1; bus.prdata = 32'h12345678;
      step();
      chk("rd_rsp_valid", bus.rsp_valid, 64'h1);
      chk("rd_rsp_rdata", bus.rsp_rdata, 64'h12345678);
      chk("rd_rsp_err",   bus.rsp_err,   64'h0);
      chk("rd_end_psel",  bus.psel,      64'h0);
      bus.pready = 1'b0; bus.prdata = 32'h0;
      step();
      chk("rd_rsp_pulse", bus.rsp_valid, 64'h0);
      chk("rd_rdata_hold", bus.rsp_rdata, 64'h12345678);

      // ---- read completing with pslverr, then a clean read
      bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 32'h30;
      bus.pready = 1'b1; bus.pslverr = 1'b1; bus.prdata = 32'hA5A5A5A5;
      step();
      bus.cmd_valid = 1'b0;
      step(); step();
      chk("err_rsp_valid", bus.rsp_valid, 64'h1);
      chk("err_rsp_err",   bus.rsp_err,   64'h1);
      chk("err_rsp_rdata", bus.rsp_rdata, 64'hA5A5A5A5);
      bus.pslverr = 1'b0; bus.prdata = 32'h0BADF00D;
      bus.cmd_valid = 1'b1; bus.cmd_addr = 32'h34;
      step();
      bus.cmd_valid = 1'b0;
      step(); step();
      chk("ok_rsp_valid", bus.rsp_valid, 64'h1);
      chk("ok_rsp_err",   bus.rsp_err,   64'h0);
      chk("ok_rsp_rdata", bus.rsp_rdata, 64'h0BADF00D);

      // ---- back-to-back writes with cmd_valid held; a transfer spans four
      // clock periods, so B is taken in the cycle A's response is shown
      bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1;
      bus.cmd_addr = 32'h40; bus.cmd_wdata = 32'h11111111; bus.pready = 1'b1;
      step();                                   // A accepted
      chk("b2b_a_psel",  bus.psel,  64'h1);
      chk("b2b_a_paddr", bus.paddr, 64'h40);
      bus.cmd_addr = 32'h44; bus.cmd_wdata = 32'h22222222;
      step();
      chk("b2b_a_pen",    bus.penable, 64'h1);
      chk("b2b_a_hold",   bus.paddr,   64'h40);
      chk("b2b_a_pwdata", bus.pwdata,  64'h11111111);
      step();
      chk("b2b_gap_psel",  bus.psel,      64'h0);
      chk("b2b_a_rsp",     bus.rsp_valid, 64'h1);
      chk("b2b_a_rdata",   bus.rsp_rdata, 64'h0);
      chk("b2b_gap_ready", bus.cmd_ready, 64'h1);
      step();                                   // B accepted
      chk("b2b_b_psel",   bus.psel,    64'h1);
      chk("b2b_b_pen",    bus.penable, 64'h0);
      chk("b2b_b_paddr",  bus.paddr,   64'h44);
      chk("b2b_b_pwdata", bus.pwdata,  64'h22222222);
      bus.cmd_valid = 1'b0;
      step();
      chk("b2b_b_access", bus.penable, 64'h1);
      step();
      chk("b2b_b_rsp", bus.rsp_valid, 64'h1);

      // ---- reset pulse during ACCESS
      bus.pready = 1'b0; bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 32'h50;
      step();
      bus.cmd_valid = 1'b0;
      step(); step();
      chk("mid_pen_pre", bus.penable, 64'h1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_psel",  bus.psel,      64'h0);
      chk("mid_rst_pen",   bus.penable,   64'h0);
      chk("mid_rst_ready", bus.cmd_ready, 64'h0);
      chk("mid_rst_rsp",   bus.rsp_valid, 64'h0);
      bus.pready = 1'b1;
      step(); step();
      rst_n = 1'b1;
      chk("mid_rel_rsp", bus.rsp_valid, 64'h0);
      step();
      chk("mid_rel_ready", bus.cmd_ready, 64'h1);
      chk("mid_rel_rsp2",  bus.rsp_valid, 64'h0);
      chk("mid_rel_psel",  bus.psel,      64'h0);
      step();
      chk("mid_rel_rsp3", bus.rsp_valid, 64'h0);

      // ---- timeout behaviour
      bus.pready = 1'b0;
`ifdef APB_M_TIMEOUT_EN
      // pready arriving in the last allowed ACCESS cycle completes normally
      bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 32'h60;
      step();
      bus.cmd_valid = 1'b0;
      step();
      for (int i = 0; i < TO_CYC - 1; i++) begin
         step();
         chk("race_wait_rsp", bus.rsp_valid, 64'h0);
      end
      bus.pready = 1'b1; bus.prdata = 32'h77777777;
      step();
      chk("race_rsp_valid", bus.rsp_valid, 64'h1);
      chk("race_rsp_err",   bus.rsp_err,   64'h0);
      chk("race_rsp_rdata", bus.rsp_rdata, 64'h77777777);
      bus.pready = 1'b0;
      step();
      // pready never arrives: abort after TO_CYC ACCESS cycles
      bus.cmd_valid = 1'b1; bus.cmd_addr = 32'h64;
      step();
      bus.cmd_valid = 1'b0;
      step();
      for (int i = 0; i < TO_CYC - 1; i++) begin
         step();
         chk("to_wait_rsp", bus.rsp_valid, 64'h0);
         chk("to_wait_pen", bus.penable,   64'h1);
      end
      step();
      chk("to_rsp_valid", bus.rsp_valid, 64'h1);
      chk("to_rsp_err",   bus.rsp_err,   64'h1);
      chk("to_rsp_rdata", bus.rsp_rdata, 64'h0);
      chk("to_end_psel",  bus.psel,      64'h0);
      chk("to_end_pen",   bus.penable,   64'h0);
      step();
      chk("to_rsp_pulse", bus.rsp_valid, 64'h0);
`else
      // without the watchdog ACCESS waits indefinitely
      bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 32'h60;
      step();
      bus.cmd_valid = 1'b0;
      step();
      for (int i = 0; i < 1000; i++) begin
         step();
         if (bus.rsp_valid === 1'b1) seen++;
      end
      chk("nto_rsp_count", 64'(seen),   64'h0);
      chk("nto_psel",      bus.psel,    64'h1);
      chk("nto_pen",       bus.penable, 64'h1);
      chk("nto_paddr",     bus.paddr,   64'h60);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule : tb_apb_m_bridge
